// File: rtl/iir_out_fifo_pkg.sv
// iir_pkg: Q-format constants shared by the IIR cascade and its output stage.
package iir_pkg;
  localparam int SAMP_WH = 3;
  localparam int SAMP_FR = 22;
  localparam int OUT_W = 16;
  localparam int SAMP_W = SAMP_WH + SAMP_FR;
  localparam int SH = SAMP_FR - (OUT_W - 1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  typedef logic signed [SAMP_W-1:0] samp_t;
  typedef logic signed [OUT_W-1:0] word_t;
endpackage

// File: rtl/iir_out_fifo_if.sv
// iir_out_fifo_if: valid/ready output stream of the IIR output stage.
interface iir_out_fifo_if #(parameter int W = iir_pkg::OUT_W);
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output out_data, out_valid, input out_ready);
  modport slave(input out_data, out_valid, output out_ready);
endinterface

// File: rtl/iir_out_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered head word and drop reporting.
module sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_empty,
  output logic                   o_drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic [W-1:0] r_rdata;
  logic w_full, w_pop, w_push;
  always_comb begin
    o_empty = r_level == '0;
    w_full = r_level == (AW+1)'(DEPTH);
    w_pop = i_pop & ~o_empty;
    w_push = i_push & (~w_full | w_pop);
    o_drop = i_push & ~w_push;
    o_level = r_level;
    o_rdata = r_rdata;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wdata;
  // Head word is registered so it can hold its last value once the FIFO empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_pop)
        r_rdata <= (r_level == (AW+1)'(1)) ? (w_push ? i_wdata : r_rdata) : r_mem[r_rptr + 1'b1];
      else if (o_empty && w_push)
        r_rdata <= i_wdata;
    end
  end
endmodule

// File: rtl/iir_out_fifo.sv
// iir_out_fifo: rounds/saturates the IIR cascade output to Q1.(OUT_W-1) and buffers it.
module iir_out_fifo #(
  parameter int SAMP_WH = iir_pkg::SAMP_WH,
  parameter int SAMP_FR = iir_pkg::SAMP_FR,
  parameter int OUT_W = iir_pkg::OUT_W,
  parameter int DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              din_stb,
  input  logic signed [SAMP_WH+SAMP_FR-1:0] din,
  iir_out_fifo_if.master                    out,
  output logic [$clog2(DEPTH):0]            level,
  output logic                              sat_flag,
  output logic                              ovf_flag,
  input  logic                              flag_clr
);
  localparam int SW = SAMP_WH + SAMP_FR;
  localparam int SH = SAMP_FR - (OUT_W - 1);
  localparam logic signed [SW:0] HALF = (SW+1)'(SH > 0 ? 2 ** (SH - 1) : 0);
  localparam logic signed [SW:0] HI = (SW+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SW:0] LO = -HI - 1;
  logic signed [SW:0] w_sum, w_r;
  logic [OUT_W-1:0] w_q, r_q;
  logic w_hi, w_lo, w_empty, w_drop;
  logic r_qv, r_sat, r_ovf;
  // One guard bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    w_sum = (SW+1)'(din) + HALF;
    w_r = w_sum >>> SH;
    w_hi = w_r > HI;
    w_lo = w_r < LO;
    w_q = w_hi ? {1'b0, {(OUT_W-1){1'b1}}} : w_lo ? {1'b1, {(OUT_W-1){1'b0}}} : w_r[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qv <= 1'b0;
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_qv <= din_stb;
      if (din_stb) r_q <= w_q;
      r_sat <= (din_stb & (w_hi | w_lo)) | (r_sat & ~flag_clr);
      r_ovf <= w_drop | (r_ovf & ~flag_clr);
    end
  end
  sync_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(r_qv),
    .i_wdata(r_q),
    .i_pop(out.out_ready),
    .o_rdata(out.out_data),
    .o_level(level),
    .o_empty(w_empty),
    .o_drop(w_drop)
  );
  assign out.out_valid = ~w_empty;
  assign sat_flag = r_sat;
  assign ovf_flag = r_ovf;
endmodule

// File: tb/tb_iir_out_fifo.sv
// tb_iir_out_fifo: directed scenario tests for the IIR output FIFO stage.
module tb_iir_out_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_stb = 1'b0;
  logic flag_clr = 1'b0;
  logic [24:0] din = '0;
  logic [3:0] level;
  logic sat_flag, ovf_flag;
  int errs = 0;
  int checks = 0;
  logic [24:0] rv_in [5] = '{25'h0000040, 25'h000003F, 25'h1FFFFC0, 25'h03FFFBF, 25'h1FFFFBF};
  logic [15:0] rv_exp [5] = '{16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'hFFFF};

  iir_out_fifo_if #(.W(16)) u_if ();

  iir_out_fifo dut (
    .clk(clk),
    .rst(rst),
    .din_stb(din_stb),
    .din(din),
    .out(u_if),
    .level(level),
    .sat_flag(sat_flag),
    .ovf_flag(ovf_flag),
    .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [24:0] v);
    din = v;
    din_stb = 1'b1;
    tick();
    din_stb = 1'b0;
  endtask

  task automatic pop_one;
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
  endtask

  task automatic clear_flags;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (u_if.out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%0h want=0", u_if.out_valid); end
    checks++; if (level !== 4'd0) begin errs++; $display("FAIL rst_level got=%0d want=0", level); end
    checks++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL rst_sat got=%0h want=0", sat_flag); end
    checks++; if (ovf_flag !== 1'b0) begin errs++; $display("FAIL rst_ovf got=%0h want=0", ovf_flag); end
    checks++; if (u_if.out_data !== 16'h0000) begin errs++; $display("FAIL rst_data got=%h want=0000", u_if.out_data); end
    tick();
    checks++; if (u_if.out_valid !== 1'b0) begin errs++; $display("FAIL idle_valid got=%0h want=0", u_if.out_valid); end
  endtask

  task automatic test_rounding;
    for (int i = 0; i < 5; i++) begin
      strobe(rv_in[i]);
      checks++; if (u_if.out_valid !== 1'b0) begin errs++; $display("FAIL round_lat_n1[%0d] valid got=%0h want=0", i, u_if.out_valid); end
      tick();
      checks++; if (u_if.out_valid !== 1'b1) begin errs++; $display("FAIL round_lat_n2[%0d] valid got=%0h want=1", i, u_if.out_valid); end
      checks++; if (u_if.out_data !== rv_exp[i]) begin errs++; $display("FAIL round_data[%0d] got=%h want=%h", i, u_if.out_data, rv_exp[i]); end
      pop_one();
      checks++; if (level !== 4'd0) begin errs++; $display("FAIL round_level[%0d] got=%0d want=0", i, level); end
    end
    checks++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL round_nosat got=%0h want=0", sat_flag); end
  endtask

  task automatic test_saturation;
    strobe(25'h0400000);
    tick();
    checks++; if (u_if.out_data !== 16'h7FFF) begin errs++; $display("FAIL sat_pos_data got=%h want=7fff", u_if.out_data); end
    checks++; if (sat_flag !== 1'b1) begin errs++; $display("FAIL sat_pos_flag got=%0h want=1", sat_flag); end
    pop_one();
    clear_flags();
    checks++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL sat_clr got=%0h want=0", sat_flag); end
    strobe(25'h1C00000);
    tick();
    checks++; if (u_if.out_data !== 16'h8000) begin errs++; $display("FAIL sat_m1_data got=%h want=8000", u_if.out_data); end
    checks++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL sat_m1_noclip got=%0h want=0", sat_flag); end
    pop_one();
    din = 25'h1BFFF00;
    din_stb = 1'b1;
    flag_clr = 1'b1;
    tick();
    din_stb = 1'b0;
    flag_clr = 1'b0;
    checks++; if (sat_flag !== 1'b1) begin errs++; $display("FAIL sat_set_wins got=%0h want=1", sat_flag); end
    tick();
    checks++; if (u_if.out_data !== 16'h8000) begin errs++; $display("FAIL sat_neg_data got=%h want=8000", u_if.out_data); end
    pop_one();
    clear_flags();
    checks++; if (sat_flag !== 1'b0) begin errs++; $display("FAIL sat_clr2 got=%0h want=0", sat_flag); end
  endtask

  task automatic test_fill_overflow;
    u_if.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) strobe(25'(i << 7));
    tick();
    tick();
    checks++; if (level !== 4'd8) begin errs++; $display("FAIL fill_level got=%0d want=8", level); end
    checks++; if (ovf_flag !== 1'b1) begin errs++; $display("FAIL fill_ovf got=%0h want=1", ovf_flag); end
    u_if.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 16'(i)) begin errs++; $display("FAIL drain[%0d] valid=%0h got=%h want=%h", i, u_if.out_valid, u_if.out_data, 16'(i)); end
      tick();
    end
    u_if.out_ready = 1'b0;
    checks++; if (u_if.out_valid !== 1'b0) begin errs++; $display("FAIL drain_valid got=%0h want=0", u_if.out_valid); end
    checks++; if (level !== 4'd0) begin errs++; $display("FAIL drain_level got=%0d want=0", level); end
    checks++; if (u_if.out_data !== 16'h0008) begin errs++; $display("FAIL drain_hold got=%h want=0008", u_if.out_data); end
    clear_flags();
    checks++; if (ovf_flag !== 1'b0) begin errs++; $display("FAIL ovf_clr got=%0h want=0", ovf_flag); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 11; i <= 18; i++) strobe(25'(i << 7));
    tick();
    tick();
    checks++; if (level !== 4'd8) begin errs++; $display("FAIL full_level got=%0d want=8", level); end
    din = 25'(19 << 7);
    din_stb = 1'b1;
    tick();
    din_stb = 1'b0;
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    checks++; if (level !== 4'd8) begin errs++; $display("FAIL pp_level got=%0d want=8", level); end
    checks++; if (ovf_flag !== 1'b0) begin errs++; $display("FAIL pp_ovf got=%0h want=0", ovf_flag); end
    u_if.out_ready = 1'b1;
    for (int i = 12; i <= 19; i++) begin
      checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 16'(i)) begin errs++; $display("FAIL pp_order[%0d] valid=%0h got=%h want=%h", i, u_if.out_valid, u_if.out_data, 16'(i)); end
      tick();
    end
    u_if.out_ready = 1'b0;
    checks++; if (level !== 4'd0) begin errs++; $display("FAIL pp_empty got=%0d want=0", level); end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    u_if.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      din_stb = (c < 10);
      din = 25'((20 + c) << 7);
      tick();
      checks++; if (level > 4'd1) begin errs++; $display("FAIL b2b_level[%0d] got=%0d want<=1", c, level); end
      if (u_if.out_valid === 1'b1) begin
        checks++; if (u_if.out_data !== 16'(20 + idx)) begin errs++; $display("FAIL b2b_data[%0d] got=%h want=%h", idx, u_if.out_data, 16'(20 + idx)); end
        idx++;
      end
    end
    din_stb = 1'b0;
    u_if.out_ready = 1'b0;
    checks++; if (idx != 10) begin errs++; $display("FAIL b2b_count got=%0d want=10", idx); end
  endtask

  task automatic test_reset_mid;
    for (int i = 30; i <= 34; i++) strobe(25'(i << 7));
    tick();
    tick();
    checks++; if (level !== 4'd5) begin errs++; $display("FAIL mid_level got=%0d want=5", level); end
    strobe(25'h0400000);
    checks++; if (sat_flag !== 1'b1) begin errs++; $display("FAIL mid_sat got=%0h want=1", sat_flag); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (level !== 4'd0) begin errs++; $display("FAIL mid_rst_level got=%0d want=0", level); end
    checks++; if (u_if.out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid got=%0h want=0", u_if.out_valid); end
    checks++; if (sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin errs++; $display("FAIL mid_rst_flags got=%0h%0h want=00", sat_flag, ovf_flag); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (u_if.out_valid !== 1'b0 || level !== 4'd0) begin errs++; $display("FAIL mid_inflight[%0d] valid=%0h level=%0d want 0/0", c, u_if.out_valid, level); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    u_if.out_ready = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/iir_out_fifo.md
Name: iir_out_fifo

Overview:
Output stage directly downstream of the IIR low-pass cascade. On each sample strobe it takes the cascade's wide fixed-point output, rounds and saturates it to a 16-bit Q1.15 word, and buffers it in a small FIFO. The consumer reads the FIFO over a valid/ready handshake at its own pace, typically a DAC serializer or a test capture. Sticky flags report saturation and dropped samples.

Parameters:
SAMP_WH, 3, integer bits of input sample, sign included
SAMP_FR, 22, fractional bits of input sample
OUT_W, 16, output word width, Q1.(OUT_W-1); must satisfy OUT_W-1 <= SAMP_FR
DEPTH, 8, FIFO depth in words; power of 2, >= 2

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
din_stb  in  1  one-cycle strobe: din holds a new valid filter output
din  in  SAMP_WH+SAMP_FR  signed filter output, Q(SAMP_WH).(SAMP_FR)
out_data  out  OUT_W  signed head-of-FIFO word, Q1.(OUT_W-1)
out_valid  out  1  FIFO not empty; out_data valid
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
sat_flag  out  1  sticky: at least one sample clipped
ovf_flag  out  1  sticky: at least one sample dropped because the FIFO was full
flag_clr  in  1  clears sat_flag and ovf_flag

Behaviour:
- Single clock domain. All registers are updated on the posedge of clk only.
- Reset: rst high at a clock edge clears the pointers, level=0, out_valid=0, out_data=0, sat_flag=0, ovf_flag=0, and the quantiser stage valid bit. Memory contents are don't-care. A reset mid-operation discards all buffered and in-flight samples.
- Quantiser (stage 1): SH = SAMP_FR-(OUT_W-1) = 7 by default.
  - Compute r = (din + 2^(SH-1)) >>> SH with arithmetic shift; this is round-half-up. Use SAMP_WH+SAMP_FR+1 bits internally so the add cannot wrap.
  - If r > 2^(OUT_W-1)-1, q = 0x7FFF. If r < -2^(OUT_W-1), q = 0x8000. Otherwise q = r[OUT_W-1:0].
  - Any clip sets sat_flag.
  - q and a valid bit are registered at the edge where din_stb=1.
- FIFO write (stage 2): the registered q is pushed at the next edge.
  - The push is accepted when level<DEPTH, or when level==DEPTH and a pop happens in the same cycle.
  - Otherwise the word is dropped and ovf_flag is set. Stored data is untouched.
- Latency: din_stb in cycle N gives out_valid=1 and out_data=q in cycle N+2 when the FIFO was empty.
- Read: first-word-fall-through. out_data shows the head entry whenever out_valid=1.
  - A pop occurs at an edge with out_valid && out_ready.
  - out_ready while out_valid=0 has no effect.
  - out_data holds its last value when the FIFO is empty.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Empty plus push in the same cycle: no pop occurs. The word appears next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level carries the full/empty distinction.
- Flags: when set and flag_clr occur in the same cycle, set wins.
- din_stb on consecutive cycles is legal; every strobe is processed.

Decomposition:
- Shared package iir_pkg holds:
  - SAMP_WH, SAMP_FR, OUT_W, and the derived SAMP_W = SAMP_WH+SAMP_FR and SH.
  - Saturation constants SAT_MAX and SAT_MIN.
  - The same Q-format constants used by the filter cascade, so both blocks agree.
- One sub-module, sync_fifo: DEPTH x OUT_W, FWFT, push/pop/level/full/empty.
- The quantiser and flag logic stay in the top module.

Test Plan:
- Reset then idle: after rst, out_valid=0, level=0, flags=0. Single strobe din=25'h0000040 -> out_valid in cycle N+2, out_data=0x0001. din=25'h000003F -> out_data=0x0000. din=25'h1FFFFC0 (-64) -> 0x0000, confirming half-up rounding.
- Saturation: din=25'h0400000 (+1.0) -> 0x7FFF and sat_flag=1. din=25'h1C00000 (-1.0) -> 0x8000 with no new clip. flag_clr -> sat_flag=0. din=25'h1BFFF00 -> 0x8000 and sat_flag=1 again.
- Fill and overflow: out_ready=0; 10 strobes with values 1..10 (x2^7) -> level=8 and ovf_flag=1. Drain -> outputs 1..8 in order, then out_valid=0 and level=0.
- Full with simultaneous push/pop: level=8, strobe arrives while out_ready=1 in the push cycle -> no drop, level stays 8, ovf_flag stays 0, order preserved.
- Back-to-back strobes every cycle with out_ready=1 -> one word out per cycle, level<=1, contents match the strobe order.
- Reset mid-stream: level=5 with a strobe in flight; assert rst for 1 cycle -> level=0, out_valid=0, flags=0, and the in-flight word never appears.
